// File: rtl/banner_renderer_pkg.sv
// Shared constants for the banner renderer: glyph codes, FSM state encoding
// and the visible raster limits.
package banner_renderer_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [3:0] GLYPH_BLANK = 4'd0;
   localparam logic [3:0] GLYPH_W     = 4'd1;
   localparam logic [3:0] GLYPH_I     = 4'd2;
   localparam logic [3:0] GLYPH_N     = 4'd3;
   localparam logic [3:0] GLYPH_EXCL  = 4'd4;
   localparam logic [3:0] GLYPH_L     = 4'd5;
   localparam logic [3:0] GLYPH_O     = 4'd6;
   localparam logic [3:0] GLYPH_S     = 4'd7;
   localparam logic [3:0] GLYPH_E     = 4'd8;
   localparam logic [3:0] GLYPH_T     = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REVEAL = 2'd1,
      ST_SHOW   = 2'd2
   } state_t;

endpackage

// File: rtl/banner_renderer_glyph_shape.sv
// Combinational stroke-glyph lookup: decides whether local cell coordinate
// (x,y) lies on a stroke of the glyph selected by i_code.
module glyph_shape
   import banner_renderer_pkg::*;
#(
   parameter int CELL   = 100,
   parameter int STROKE = 20
) (
   input  logic [3:0] i_code,
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   output logic       o_hit
);

   localparam logic [10:0] T        = 11'(STROKE);
   localparam logic [10:0] FAR      = 11'(CELL - STROKE);
   localparam logic [10:0] HALF     = 11'(CELL / 2);
   localparam logic [10:0] MID_LO   = 11'(CELL / 2 - STROKE / 2);
   localparam logic [10:0] MID_HI   = 11'(CELL / 2 + STROKE / 2);
   localparam logic [10:0] BANG_END = 11'(CELL - 2 * STROKE);

   logic [10:0] w_x;
   logic [10:0] w_y;
   logic        w_left;
   logic        w_right;
   logic        w_top;
   logic        w_bottom;
   logic        w_mid_x;
   logic        w_mid_y;
   logic        w_diag;

   assign w_x = {1'b0, i_x};
   assign w_y = {1'b0, i_y};

   always_comb begin
      w_left   = (w_x < T);
      w_right  = (w_x >= FAR);
      w_top    = (w_y < T);
      w_bottom = (w_y >= FAR);
      w_mid_x  = (w_x >= MID_LO) && (w_x < MID_HI);
      w_mid_y  = (w_y >= MID_LO) && (w_y < MID_HI);
      // N diagonal: a band of width t running from the top-left corner down-right
      w_diag   = (w_y <= w_x) && (w_x < w_y + T);

      case (i_code)
         GLYPH_W:    o_hit = w_left || w_right || w_bottom || (w_mid_x && (w_y >= HALF));
         GLYPH_I:    o_hit = w_left;
         GLYPH_N:    o_hit = w_left || w_right || w_diag;
         GLYPH_EXCL: o_hit = w_left && ((w_y < BANG_END) || w_bottom);
         GLYPH_L:    o_hit = w_left || w_bottom;
         GLYPH_O:    o_hit = w_left || w_right || w_top || w_bottom;
         GLYPH_S:    o_hit = w_top || w_bottom || w_mid_y ||
                             (w_left && (w_y < HALF)) || (w_right && (w_y >= HALF));
         GLYPH_E:    o_hit = w_left || w_top || w_bottom || w_mid_y;
         GLYPH_T:    o_hit = w_top || w_mid_x;
         default:    o_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/banner_renderer.sv
// Animated N-glyph banner: reveals glyphs one per REVEAL_FRAMES ticks, then holds.
// Define BANNER_BLINK_EN to blink the completed message every BLINK_FRAMES ticks.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | banner blank, waiting for start
//   ST_REVEAL | glyphs appearing one at a time on frame ticks (busy)
//   ST_SHOW   | full message shown, optionally blinking (done)
module banner_renderer
   import banner_renderer_pkg::*;
#(
   parameter int          H_ORIGIN      = 160,
   parameter int          V_ORIGIN      = 200,
   parameter int          CELL          = 100,
   parameter int          STROKE        = 20,
   parameter int          GAP           = 20,
   parameter int          NUM_GLYPHS    = 4,
   parameter logic [31:0] MSG           = 32'h0000_4321,
   parameter int          REVEAL_FRAMES = 15,
   parameter int          BLINK_FRAMES  = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  start,
   input  logic                  clear,
   input  logic [9:0]            H_Coord,
   input  logic [9:0]            V_Coord,
   output logic [NUM_GLYPHS-1:0] glyph_mask,
   output logic                  pixel_on,
   output logic                  busy,
   output logic                  done
);

   localparam int PITCH   = CELL + GAP;
   localparam int CNT_MAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             r_state;
   logic [3:0]         r_revealed;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic               r_busy;
   logic               r_done;
   logic               w_blink_on;

   logic [2:0]         w_k;
   logic [9:0]         w_x;
   logic [9:0]         w_y;
   logic               w_h_ok;
   logic               w_v_ok;
   logic               w_in_range;

   logic [2:0]         r_k;
   logic [9:0]         r_x;
   logic [9:0]         r_y;
   logic               r_in_range;

   logic [3:0]            w_code;
   logic                  w_hit;
   logic [NUM_GLYPHS-1:0] w_mask;
   logic [NUM_GLYPHS-1:0] r_glyph_mask;
   logic                  r_pixel_on;

`ifdef BANNER_BLINK_EN
   logic r_blink_on;
   assign w_blink_on = r_blink_on;
`else
   assign w_blink_on = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state     <= ST_IDLE;
         r_revealed  <= '0;
         r_frame_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef BANNER_BLINK_EN
         r_blink_on  <= 1'b1;
`endif
      end else if (start) begin
         r_revealed  <= 4'd1;
         r_frame_cnt <= '0;
`ifdef BANNER_BLINK_EN
         r_blink_on  <= 1'b1;
`endif
         if (NUM_GLYPHS == 1) begin
            r_state <= ST_SHOW;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end else begin
            r_state <= ST_REVEAL;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
         end
      end else begin
         case (r_state)
            ST_REVEAL: begin
               if (frame_tick) begin
                  if (r_frame_cnt == CNT_W'(REVEAL_FRAMES - 1)) begin
                     r_frame_cnt <= '0;
                     r_revealed  <= r_revealed + 4'd1;
                     if (r_revealed == 4'(NUM_GLYPHS - 1)) begin
                        r_state <= ST_SHOW;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef BANNER_BLINK_EN
                        r_blink_on <= 1'b1;
`endif
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                  end
               end
            end
`ifdef BANNER_BLINK_EN
            ST_SHOW: begin
               if (frame_tick) begin
                  if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                     r_frame_cnt <= '0;
                     r_blink_on  <= ~r_blink_on;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Cell index via a compare chain against each cell's left edge; all compares
   // happen before any subtraction so nothing can wrap.
   always_comb begin
      w_k = '0;
      w_x = '0;
      w_y = '0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
         if ({1'b0, H_Coord} >= 11'(H_ORIGIN + i * PITCH)) begin
            w_k = 3'(i);
            w_x = 10'({1'b0, H_Coord} - 11'(H_ORIGIN + i * PITCH));
         end
      end
      w_h_ok = ({1'b0, H_Coord} >= 11'(H_ORIGIN));
      w_v_ok = ({1'b0, V_Coord} >= 11'(V_ORIGIN));
      if (w_v_ok) begin
         w_y = 10'({1'b0, V_Coord} - 11'(V_ORIGIN));
      end
      w_in_range = w_h_ok && w_v_ok && (w_y < 10'(CELL)) && (w_x < 10'(CELL)) &&
                   ({1'b0, w_k} < 4'(NUM_GLYPHS));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_k        <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_in_range <= 1'b0;
      end else begin
         r_k        <= w_k;
         r_x        <= w_x;
         r_y        <= w_y;
         r_in_range <= w_in_range;
      end
   end

   assign w_code = MSG[{r_k, 2'b00} +: 4];

   glyph_shape #(
      .CELL   (CELL),
      .STROKE (STROKE)
   ) u_glyph_shape (
      .i_code (w_code),
      .i_x    (r_x),
      .i_y    (r_y),
      .o_hit  (w_hit)
   );

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
         w_mask[i] = r_in_range && (r_k == 3'(i)) && w_hit &&
                     (4'(i) < r_revealed) && w_blink_on;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_glyph_mask <= '0;
         r_pixel_on   <= 1'b0;
      end else begin
         r_glyph_mask <= w_mask;
         r_pixel_on   <= |w_mask;
      end
   end

   assign glyph_mask = r_glyph_mask;
   assign pixel_on   = r_pixel_on;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_banner_renderer.sv
// Self-checking bench for banner_renderer: reveal timing, priorities, reset abort,
// blink (when BANNER_BLINK_EN is defined) and a raster sweep against a pixel model.
`timescale 1ns/1ps
module tb_banner_renderer;
   import banner_renderer_pkg::*;

   localparam int H0     = 160;
   localparam int V0     = 200;
   localparam int CELL   = 100;
   localparam int STROKE = 20;
   localparam int GAP    = 20;
   localparam int PITCH  = CELL + GAP;
   localparam int NG     = 4;
   localparam int RF     = 15;
   localparam int BF     = 30;
   localparam logic [31:0] MSG_A = 32'h0000_4321;
   localparam logic [31:0] MSG_B = 32'h0000_9665;
   localparam logic [31:0] MSG_C = 32'h0000_0002;
`ifdef BANNER_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, frame_tick, start, clear;
   logic [9:0] h_coord, v_coord;
   logic [3:0] mask_a, mask_b;
   logic [0:0] mask_c;
   logic       pon_a, busy_a, done_a;
   logic       pon_b, busy_b, done_b;
   logic       pon_c, busy_c, done_c;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   banner_renderer #(.H_ORIGIN(H0), .V_ORIGIN(V0), .CELL(CELL), .STROKE(STROKE), .GAP(GAP),
      .NUM_GLYPHS(NG), .MSG(MSG_A), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)) dut_a (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .clear(clear),
      .H_Coord(h_coord), .V_Coord(v_coord), .glyph_mask(mask_a), .pixel_on(pon_a),
      .busy(busy_a), .done(done_a));

   banner_renderer #(.H_ORIGIN(H0), .V_ORIGIN(V0), .CELL(CELL), .STROKE(STROKE), .GAP(GAP),
      .NUM_GLYPHS(NG), .MSG(MSG_B), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)) dut_b (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .clear(clear),
      .H_Coord(h_coord), .V_Coord(v_coord), .glyph_mask(mask_b), .pixel_on(pon_b),
      .busy(busy_b), .done(done_b));

   banner_renderer #(.H_ORIGIN(H0), .V_ORIGIN(V0), .CELL(CELL), .STROKE(STROKE), .GAP(GAP),
      .NUM_GLYPHS(1), .MSG(MSG_C), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)) dut_c (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .clear(clear),
      .H_Coord(h_coord), .V_Coord(v_coord), .glyph_mask(mask_c), .pixel_on(pon_c),
      .busy(busy_c), .done(done_c));

   // Reference glyph rules on local cell coordinates.
   function automatic bit shape(int c, int x, int y);
      int t, h;
      bit mx, my;
      t  = STROKE;
      h  = CELL / 2;
      mx = (x >= h - t / 2) && (x < h + t / 2);
      my = (y >= h - t / 2) && (y < h + t / 2);
      case (c)
         1: return (x < t) || (x >= CELL - t) || (y >= CELL - t) || (mx && y >= h);
         2: return (x < t);
         3: return (x < t) || (x >= CELL - t) || ((y <= x) && (x < y + t));
         4: return (x < t) && ((y < CELL - 2 * t) || (y >= CELL - t));
         5: return (x < t) || (y >= CELL - t);
         6: return (x < t) || (x >= CELL - t) || (y < t) || (y >= CELL - t);
         7: return (y < t) || (y >= CELL - t) || my || ((x < t) && (y < h)) ||
                   ((x >= CELL - t) && (y >= h));
         8: return (x < t) || (y < t) || (y >= CELL - t) || my;
         9: return (y < t) || mx;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] model_mask(logic [31:0] msg, int n, int h, int v,
                                             int rev, bit blink_on);
      int dx, k, x, y, code;
      logic [7:0] m;
      m = 8'h00;
      if (h < H0 || v < V0 || !blink_on) return m;
      dx = h - H0;
      k  = dx / PITCH;
      x  = dx % PITCH;
      y  = v - V0;
      if (k >= n || x >= CELL || y >= CELL || k >= rev) return m;
      code = int'((msg >> (4 * k)) & 32'hF);
      if (shape(code, x, y)) m[k] = 1'b1;
      return m;
   endfunction

   function automatic int rev_after(int ticks);
      int r;
      r = 1 + ticks / RF;
      return (r > NG) ? NG : r;
   endfunction

   function automatic bit blink_after(int show_ticks);
      return !BLINK || (((show_ticks / BF) % 2) == 0);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cycle();
         frame_tick = 1'b0;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   task automatic probe(int h, int v);
      h_coord = 10'(h);
      v_coord = 10'(v);
      cycle();
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cycle();
      checks++;
      if (mask_a !== 4'b0000 || pon_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: mask=%b pon=%b busy=%b done=%b, expected all 0",
                  mask_a, pon_a, busy_a, done_a);
      end
      reset = 1'b0;
      probe(165, 205);
      checks++;
      if (mask_a !== 4'b0000) begin
         errors++;
         $display("FAIL idle_blank: mask=%b expected 0000", mask_a);
      end
   endtask

   task automatic test_static();
      logic [7:0] e;
      int h, v;
      pulse_clear();
      pulse_start();
      tick(45);
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL static_done: busy=%b done=%b expected busy=0 done=1", busy_a, done_a);
      end
      probe(165, 205);
      checks++;
      if (mask_a !== 4'b0001) begin errors++; $display("FAIL static_165_205: mask=%b expected 0001", mask_a); end
      probe(290, 205);
      checks++;
      if (mask_a !== 4'b0010) begin errors++; $display("FAIL static_290_205: mask=%b expected 0010", mask_a); end
      probe(159, 205);
      checks++;
      if (mask_a !== 4'b0000) begin errors++; $display("FAIL static_159_205: mask=%b expected 0000", mask_a); end
      probe(165, 199);
      checks++;
      if (mask_a !== 4'b0000) begin errors++; $display("FAIL static_165_199: mask=%b expected 0000", mask_a); end
      probe(260, 205);
      checks++;
      if (pon_a !== 1'b0 || mask_a !== 4'b0000) begin
         errors++;
         $display("FAIL static_gap: mask=%b pon=%b expected 0000/0", mask_a, pon_a);
      end
      for (int i = 0; i < 60; i++) begin
         h = int'($urandom_range(150, 620));
         v = int'($urandom_range(190, 310));
         probe(h, v);
         e = model_mask(MSG_A, NG, h, v, NG, 1'b1);
         checks++;
         if (mask_a !== e[3:0] || pon_a !== (|e)) begin
            errors++;
            $display("FAIL static_rand(%0d,%0d): mask=%b pon=%b expected %b", h, v, mask_a, pon_a, e[3:0]);
         end
      end
   endtask

   task automatic test_reveal();
      logic [7:0] e;
      int h, v;
      pulse_clear();
      pulse_start();
      for (int n = 0; n <= 46; n++) begin
         probe(520, 205);
         checks++;
         if (pon_a !== (n >= 45)) begin
            errors++;
            $display("FAIL reveal_glyph3 tick %0d: pixel_on=%b expected %b", n, pon_a, (n >= 45));
         end
         checks++;
         if (busy_a !== (n < 45) || done_a !== (n >= 45)) begin
            errors++;
            $display("FAIL reveal_flags tick %0d: busy=%b done=%b expected %b/%b",
                     n, busy_a, done_a, (n < 45), (n >= 45));
         end
         h = int'($urandom_range(150, 620));
         v = int'($urandom_range(190, 310));
         probe(h, v);
         e = model_mask(MSG_A, NG, h, v, rev_after(n), 1'b1);
         checks++;
         if (mask_a !== e[3:0]) begin
            errors++;
            $display("FAIL reveal_rand tick %0d (%0d,%0d): mask=%b expected %b", n, h, v, mask_a, e[3:0]);
         end
         tick(1);
      end
   endtask

   task automatic test_start_tick_same();
      pulse_clear();
      start      = 1'b1;
      frame_tick = 1'b1;
      cycle();
      start      = 1'b0;
      frame_tick = 1'b0;
      probe(165, 205);
      checks++;
      if (mask_a !== 4'b0001 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL start_tick_rev1: mask=%b busy=%b expected 0001/1", mask_a, busy_a);
      end
      tick(14);
      probe(290, 205);
      checks++;
      if (mask_a !== 4'b0000) begin
         errors++;
         $display("FAIL start_tick_14: mask=%b expected 0000 (tick with start must be ignored)", mask_a);
      end
      tick(1);
      probe(290, 205);
      checks++;
      if (mask_a !== 4'b0010) begin
         errors++;
         $display("FAIL start_tick_15: mask=%b expected 0010", mask_a);
      end
   endtask

   task automatic test_clear_start();
      pulse_start();
      tick(3);
      clear = 1'b1;
      start = 1'b1;
      cycle();
      clear = 1'b0;
      start = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL clear_start_flags: busy=%b done=%b expected 0/0", busy_a, done_a);
      end
      probe(165, 205);
      checks++;
      if (mask_a !== 4'b0000 || pon_a !== 1'b0) begin
         errors++;
         $display("FAIL clear_start_blank: mask=%b pon=%b expected 0000/0", mask_a, pon_a);
      end
   endtask

   task automatic test_reset_mid();
      pulse_clear();
      pulse_start();
      h_coord = 10'd165;
      v_coord = 10'd205;
      tick(20);
      reset = 1'b1;
      cycle();
      checks++;
      if (mask_a !== 4'b0000 || busy_a !== 1'b0 || done_a !== 1'b0 || pon_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: mask=%b busy=%b done=%b pon=%b expected all 0",
                  mask_a, busy_a, done_a, pon_a);
      end
      reset = 1'b0;
      cycle();
      pulse_start();
      probe(165, 205);
      checks++;
      if (mask_a !== 4'b0001) begin errors++; $display("FAIL rereveal_g0: mask=%b expected 0001", mask_a); end
      probe(290, 205);
      checks++;
      if (mask_a !== 4'b0000) begin errors++; $display("FAIL rereveal_g1_hidden: mask=%b expected 0000", mask_a); end
      tick(15);
      probe(290, 205);
      checks++;
      if (mask_a !== 4'b0010) begin errors++; $display("FAIL rereveal_g1: mask=%b expected 0010", mask_a); end
   endtask

   task automatic test_blink();
      int s;
      pulse_clear();
      pulse_start();
      tick(45);
      s = 0;
      for (int step = 0; step < 4; step++) begin
         probe(165, 205);
         checks++;
         if (pon_a !== blink_after(s) || done_a !== 1'b1) begin
            errors++;
            $display("FAIL blink show_tick %0d: pixel_on=%b done=%b expected %b/1",
                     s, pon_a, done_a, blink_after(s));
         end
         tick((step == 0) ? 29 : ((step == 1) ? 1 : 30));
         s += (step == 0) ? 29 : ((step == 1) ? 1 : 30);
      end
   endtask

   task automatic test_num1();
      pulse_clear();
      pulse_start();
      checks++;
      if (done_c !== 1'b1 || busy_c !== 1'b0) begin
         errors++;
         $display("FAIL num1_flags: busy=%b done=%b expected 0/1", busy_c, done_c);
      end
      probe(165, 205);
      checks++;
      if (mask_c !== 1'b1 || pon_c !== 1'b1) begin
         errors++;
         $display("FAIL num1_pixel: mask=%b pon=%b expected 1/1", mask_c, pon_c);
      end
   endtask

   task automatic test_loot();
      int hq[$];
      int vq[$];
      logic [7:0] eq[$];
      logic [7:0] e;
      pulse_clear();
      pulse_start();
      tick(45);
      h_coord = 10'd100;
      v_coord = 10'd100;
      repeat (3) cycle();
      h_coord = 10'd165;
      v_coord = 10'd205;
      cycle();
      checks++;
      if (mask_b !== 4'b0000) begin errors++; $display("FAIL latency_1clk: mask=%b expected 0000", mask_b); end
      cycle();
      checks++;
      if (mask_b !== 4'b0001) begin errors++; $display("FAIL latency_2clk: mask=%b expected 0001", mask_b); end

      for (int v = 190; v <= 310; v += 2)
         for (int h = 150; h <= 620; h += 3) begin
            hq.push_back(h);
            vq.push_back(v);
         end
      for (int i = 0; i < 1500; i++) begin
         hq.push_back(int'($urandom_range(0, SCREEN_W - 1)));
         vq.push_back(int'($urandom_range(0, SCREEN_H - 1)));
      end
      for (int i = 0; i < hq.size() + 2; i++) begin
         cycle();
         if (eq.size() >= 2) begin
            e = eq.pop_front();
            checks++;
            if (mask_b !== e[3:0]) begin
               errors++;
               $display("FAIL loot_raster #%0d: mask=%b expected %b", i - 2, mask_b, e[3:0]);
            end
         end
         if (i < hq.size()) begin
            h_coord = 10'(hq[i]);
            v_coord = 10'(vq[i]);
            eq.push_back(model_mask(MSG_B, NG, hq[i], vq[i], NG, 1'b1));
         end else begin
            eq.push_back(8'h00);
         end
      end
   endtask

   initial begin
      int end_h, end_v;
      reset      = 1'b1;
      frame_tick = 1'b0;
      start      = 1'b0;
      clear      = 1'b0;
      h_coord    = '0;
      v_coord    = '0;
      end_h = H0 + NG * PITCH - GAP - 1;
      end_v = V0 + CELL - 1;
      if (end_h > SCREEN_W - 1 || end_v > SCREEN_H - 1 || 2 * STROKE >= CELL) begin
         $display("FAIL param_limits: right=%0d bottom=%0d exceed %0d/%0d",
                  end_h, end_v, SCREEN_W - 1, SCREEN_H - 1);
         $fatal(1, "banner parameters out of range");
      end
      test_reset();
      test_static();
      test_reveal();
      test_start_tick_same();
      test_clear_start();
      test_reset_mid();
      test_blink();
      test_num1();
      test_loot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
